// File: rtl/output_pool_compare.sv
// output_pool_compare: per-lane signed max-pool or bypass of PE results into one registered word per window.
// Optional macro POOL_RELU_EN clamps negative emitted lanes to zero.
module output_pool_compare #(
    parameter int DATA_W  = 16,
    parameter int LANES   = 6,
    parameter int WIN_MAX = 4
) (
    input  logic                      CLK,
    input  logic                      RSTL,
    input  logic                      O_COMPARE_EN,
    input  logic                      O_COMPARE_MODE,
    input  logic                      O_COMPARE_REGEN,
    input  logic                      O_COMPARE_SWITCH,
    input  logic [LANES-1:0]          OUTPUT_EN_CTRL,
    input  logic [LANES*DATA_W-1:0]   DIN,
    output logic [LANES*DATA_W-1:0]   DOUT,
    output logic                      DOUT_VALID,
    output logic [LANES-1:0]          DOUT_LANE_MASK,
    output logic                      CMP_BUSY,
    output logic                      OVR_ERR
);
    typedef enum logic {IDLE, ACCUM} state_t;
    localparam logic [2:0] WIN_LIM = 3'(WIN_MAX);
    state_t state, state_n;
    logic [LANES*DATA_W-1:0] acc, acc_n, res;
    logic [LANES-1:0] mask, mask_n;
    logic [2:0] cnt, cnt_n;
    logic first, emit, ovr_set;
    // IDLE implies a reload, so the first sample of every window behaves like REGEN
    always_comb begin
        first   = (state == IDLE) || O_COMPARE_REGEN;
        mask_n  = (first || O_COMPARE_MODE) ? OUTPUT_EN_CTRL : (mask & OUTPUT_EN_CTRL);
        cnt_n   = first ? 3'd1 : (&cnt ? cnt : cnt + 3'd1);
        emit    = O_COMPARE_EN && (O_COMPARE_MODE || O_COMPARE_SWITCH);
        state_n = O_COMPARE_EN ? ((O_COMPARE_MODE || O_COMPARE_SWITCH) ? IDLE : ACCUM) : state;
        ovr_set = O_COMPARE_EN && !O_COMPARE_MODE && !O_COMPARE_SWITCH && (cnt_n > WIN_LIM);
    end
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [DATA_W-1:0] a, d, m, v;
        assign a = acc[i*DATA_W +: DATA_W];
        assign d = DIN[i*DATA_W +: DATA_W];
        assign m = (first || d > a) ? d : a;
        assign v = O_COMPARE_MODE ? d : m;
        assign acc_n[i*DATA_W +: DATA_W] = OUTPUT_EN_CTRL[i] ? m : a;
`ifdef POOL_RELU_EN
        assign res[i*DATA_W +: DATA_W] = (mask_n[i] && !v[DATA_W-1]) ? v : '0;
`else
        assign res[i*DATA_W +: DATA_W] = mask_n[i] ? v : '0;
`endif
    end
    always_ff @(posedge CLK) begin
        if (RSTL) begin
            state          <= IDLE;
            acc            <= '0;
            mask           <= '0;
            cnt            <= '0;
            DOUT           <= '0;
            DOUT_VALID     <= 1'b0;
            DOUT_LANE_MASK <= '0;
            OVR_ERR        <= 1'b0;
        end else begin
            state      <= state_n;
            DOUT_VALID <= emit;
            if (O_COMPARE_EN && !O_COMPARE_MODE) begin
                acc  <= acc_n;
                mask <= mask_n;
            end
            if (O_COMPARE_EN)
                cnt <= (O_COMPARE_MODE || O_COMPARE_SWITCH) ? 3'd0 : cnt_n;
            if (emit) begin
                DOUT           <= res;
                DOUT_LANE_MASK <= mask_n;
            end
            if (ovr_set)
                OVR_ERR <= 1'b1;
        end
    end
    assign CMP_BUSY = (state == ACCUM);
endmodule

// File: tb/tb_output_pool_compare.sv
// tb_output_pool_compare: table-driven vectors with an expected-result queue for output_pool_compare.
module tb_output_pool_compare;
    localparam int DW = 16;
    localparam int L  = 6;
    logic CLK = 1'b0, RSTL = 1'b1, EN = 1'b0, MODE = 1'b0, REGEN = 1'b0, SW = 1'b0;
    logic [L-1:0] CTRL = '0;
    logic [L*DW-1:0] DIN = '0;
    logic [L*DW-1:0] DOUT;
    logic DOUT_VALID, CMP_BUSY, OVR_ERR;
    logic [L-1:0] DOUT_LANE_MASK;
    typedef struct {
        logic en, mode, regen, sw;
        logic [L-1:0] ctrl;
        logic [L*DW-1:0] din;
        logic emit;
        logic [L*DW-1:0] dout;
        logic [L-1:0] mask;
        logic busy;
    } vec_t;
    vec_t tbl[$];
    logic [L*DW+L-1:0] q[$];
    logic [L*DW+L-1:0] got;
    logic [L*DW-1:0] last_dout;
    int n_cmp = 0, n_err = 0;

    output_pool_compare dut (
        .CLK(CLK), .RSTL(RSTL), .O_COMPARE_EN(EN), .O_COMPARE_MODE(MODE),
        .O_COMPARE_REGEN(REGEN), .O_COMPARE_SWITCH(SW), .OUTPUT_EN_CTRL(CTRL), .DIN(DIN),
        .DOUT(DOUT), .DOUT_VALID(DOUT_VALID), .DOUT_LANE_MASK(DOUT_LANE_MASK),
        .CMP_BUSY(CMP_BUSY), .OVR_ERR(OVR_ERR)
    );

    always #5 CLK = ~CLK;

    function automatic logic [L*DW-1:0] ln(input int a, b = 0, c = 0, d = 0, e = 0, f = 0);
        return {16'(f), 16'(e), 16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic logic [DW-1:0] rl(input int x);
`ifdef POOL_RELU_EN
        return (x < 0) ? 16'h0 : 16'(x);
`else
        return 16'(x);
`endif
    endfunction

    function automatic logic [L*DW-1:0] ex(input int a, b = 0, c = 0, d = 0, e = 0, f = 0);
        return {rl(f), rl(e), rl(d), rl(c), rl(b), rl(a)};
    endfunction

    function automatic vec_t mkv(input logic en, mode, regen, sw, input logic [L-1:0] ctrl,
                                 input logic [L*DW-1:0] din, input logic emit,
                                 input logic [L*DW-1:0] dout, input logic [L-1:0] mask, input logic busy);
        vec_t t;
        t.en = en; t.mode = mode; t.regen = regen; t.sw = sw; t.ctrl = ctrl; t.din = din;
        t.emit = emit; t.dout = dout; t.mask = mask; t.busy = busy;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [L*DW+L-1:0] act, input logic [L*DW+L-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // drive at negedge, check #1 after the edge, return at the next negedge
    task automatic apply(input vec_t t);
        EN = t.en; MODE = t.mode; REGEN = t.regen; SW = t.sw; CTRL = t.ctrl; DIN = t.din;
        if (t.emit) begin
            q.push_back({t.mask, t.dout});
            last_dout = t.dout;
        end
        @(posedge CLK);
        #1;
        chk("busy", CMP_BUSY, t.busy);
        chk("valid", DOUT_VALID, t.emit);
        if (DOUT_VALID && q.size() > 0) begin
            got = q.pop_front();
            chk("dout", DOUT, got[L*DW-1:0]);
            chk("lane_mask", DOUT_LANE_MASK, got[L*DW+L-1:L*DW]);
        end
        @(negedge CLK);
    endtask

    initial begin
        tbl.push_back(mkv(1, 0, 1, 0, 6'h3F, ln(5, -8),   0, '0, '0, 1));
        tbl.push_back(mkv(1, 0, 0, 0, 6'h3F, ln(-3, -2),  0, '0, '0, 1));
        tbl.push_back(mkv(1, 0, 0, 0, 6'h3F, ln(12, -20), 0, '0, '0, 1));
        tbl.push_back(mkv(1, 0, 0, 1, 6'h3F, ln(7, -5),   1, ex(12, -2), 6'h3F, 0));
        tbl.push_back(mkv(0, 0, 1, 1, 6'h3F, ln(99, 99),  0, '0, '0, 0));
        tbl.push_back(mkv(1, 0, 1, 1, 6'h3F, ln(0, 0, 9), 1, ex(0, 0, 9), 6'h3F, 0));
        tbl.push_back(mkv(1, 0, 1, 0, 6'h3F, ln(0, 0, 4), 0, '0, '0, 1));
        tbl.push_back(mkv(1, 0, 0, 1, 6'h3F, ln(0, 0, 6), 1, ex(0, 0, 6), 6'h3F, 0));
        tbl.push_back(mkv(1, 0, 1, 0, 6'h3F, ln(1, 2, 3, 4, 5, 6), 0, '0, '0, 1));
        tbl.push_back(mkv(1, 0, 0, 1, 6'h05, ln(7, 1, 1, 1, 1, 1), 1, ex(7, 0, 3), 6'h05, 0));
        tbl.push_back(mkv(1, 0, 1, 0, 6'h3F, ln(100), 0, '0, '0, 1));
        tbl.push_back(mkv(1, 0, 1, 0, 6'h3F, ln(-1),  0, '0, '0, 1));
        tbl.push_back(mkv(1, 0, 0, 1, 6'h3F, ln(-4),  1, ex(-1), 6'h3F, 0));
        tbl.push_back(mkv(1, 1, 0, 0, 6'h3F, ln(11, -7), 1, ex(11, -7), 6'h3F, 0));
        tbl.push_back(mkv(1, 1, 0, 0, 6'h03, ln(21, 22, 23), 1, ex(21, 22), 6'h03, 0));
        tbl.push_back(mkv(1, 1, 1, 1, 6'h3F, ln(31), 1, ex(31), 6'h3F, 0));
        tbl.push_back(mkv(0, 0, 0, 0, 6'h3F, ln(0), 0, '0, '0, 0));

        repeat (2) @(negedge CLK);
        chk("rst_dout", DOUT, '0);
        chk("rst_valid", DOUT_VALID, 1'b0);
        chk("rst_mask", DOUT_LANE_MASK, '0);
        chk("rst_busy", CMP_BUSY, 1'b0);
        chk("rst_ovr", OVR_ERR, 1'b0);
        RSTL = 1'b0;

        foreach (tbl[i]) apply(tbl[i]);
        chk("dout_hold", DOUT, last_dout);

        // reset with a window open discards it, even with EN+SWITCH asserted
        apply(mkv(1, 0, 1, 0, 6'h3F, ln(80), 0, '0, '0, 1));
        apply(mkv(1, 0, 0, 0, 6'h3F, ln(90), 0, '0, '0, 1));
        RSTL = 1'b1;
        apply(mkv(1, 0, 0, 1, 6'h3F, ln(95), 0, '0, '0, 0));
        RSTL = 1'b0;
        chk("mid_rst_dout", DOUT, '0);
        chk("mid_rst_mask", DOUT_LANE_MASK, '0);
        apply(mkv(1, 0, 0, 0, 6'h3F, ln(-5), 0, '0, '0, 1));
        apply(mkv(1, 0, 0, 1, 6'h3F, ln(-9), 1, ex(-5), 6'h3F, 0));

        for (int k = 1; k <= 5; k++) begin
            apply(mkv(1, 0, k == 1, 0, 6'h3F, ln(k), 0, '0, '0, 1));
            if (k == 4) chk("ovr_at4", OVR_ERR, 1'b0);
            if (k == 5) chk("ovr_at5", OVR_ERR, 1'b1);
        end
        apply(mkv(1, 0, 0, 1, 6'h3F, ln(6), 1, ex(6), 6'h3F, 0));
        chk("ovr_after_sw", OVR_ERR, 1'b1);
        apply(mkv(0, 0, 0, 0, 6'h3F, ln(0), 0, '0, '0, 0));
        chk("ovr_sticky", OVR_ERR, 1'b1);
        RSTL = 1'b1;
        apply(mkv(0, 0, 0, 0, 6'h3F, ln(0), 0, '0, '0, 0));
        RSTL = 1'b0;
        chk("ovr_clear", OVR_ERR, 1'b0);
        chk("queue_empty", 102'(q.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
